// File: rtl/operand_sel_pipe.sv
// Registered N:1 operand selector with valid/ready handshake and skid buffer.
// Ports: clk, rst, flush, src_data, sel, in_valid/in_ready, out_* and out_ready.
module operand_sel_pipe #(
  parameter int WIDTH = 16,
  parameter int N_SRC = 3,
  parameter int SEL_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [N_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [SEL_W-1:0]       out_tag,
  output logic                   out_err,
  output logic                   out_valid,
  input  logic                   out_ready
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] tag;
    logic             err;
  } ent_t;

  // State encoding is {out_valid, skid_full}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HALF  = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t state_q, state_d;
  ent_t   out_q, out_d;
  ent_t   skid_q, skid_d;
  ent_t   sel_ent;
  logic   accept, drain;

  // Out-of-range selects yield zero data and a raised error flag.
  always_comb begin
    sel_ent.data = '0;
    sel_ent.tag  = sel;
    sel_ent.err  = 1'b1;
    for (int k = 0; k < N_SRC; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_ent.data = src_data[k*WIDTH +: WIDTH];
        sel_ent.err  = 1'b0;
      end
    end
  end

  // Ready depends only on the skid flop, never on out_ready.
  assign in_ready  = !state_q[0] && !rst;
  assign out_valid = state_q[1];
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          out_d   = sel_ent;
          state_d = HALF;
        end
      end
      HALF: begin
        if (accept && drain) begin
          out_d = sel_ent;
        end else if (accept) begin
          skid_d  = sel_ent;
          state_d = FULL;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          out_d   = skid_q;
          state_d = HALF;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops valids only; payload registers keep their values.
    if (flush) begin
      state_d = EMPTY;
      out_d   = out_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign out_data = out_q.data;
  assign out_tag  = out_q.tag;
  assign out_err  = out_q.err;

endmodule

// File: tb/tb_operand_sel_pipe.sv
// Scoreboard bench for operand_sel_pipe.
// Directed steps followed by a constrained random phase.
module tb_operand_sel_pipe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [47:0] src_data;
  logic [1:0]  sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic [1:0]  out_tag;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;

  logic [15:0] srcv [3];

  typedef struct {
    logic [15:0] d;
    logic [1:0]  t;
    logic        e;
  } exp_t;

  exp_t q[$];

  int checks;
  int errors;

  bit          hold_chk;
  logic [15:0] held_d;
  logic [1:0]  held_t;
  logic        held_e;

  operand_sel_pipe #(
    .WIDTH(16),
    .N_SRC(3),
    .SEL_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .src_data(src_data),
    .sel(sel),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_tag(out_tag),
    .out_err(out_err),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb src_data = {srcv[2], srcv[1], srcv[0]};

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t expect_of(logic [1:0] s);
    exp_t r;
    r.t = s;
    if (s < 2'd3) begin
      r.d = srcv[s];
      r.e = 1'b0;
    end else begin
      r.d = 16'h0000;
      r.e = 1'b1;
    end
    return r;
  endfunction

  // One clock: check state against model, then advance model and edge.
  task automatic tick();
    bit acc;
    bit drn;
    logic rdy0;
    #1;
    chk("in_ready", in_ready, !rst && q.size() < 2);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_data", out_data, q[0].d);
      chk("out_tag", out_tag, q[0].t);
      chk("out_err", out_err, q[0].e);
    end
    if (hold_chk) begin
      chk("hold_data", out_data, held_d);
      chk("hold_tag", out_tag, held_t);
      chk("hold_err", out_err, held_e);
    end
    rdy0 = in_ready;
    out_ready = !out_ready;
    #1;
    chk("ready_comb", in_ready, rdy0);
    out_ready = !out_ready;
    #1;
    acc = in_valid && in_ready;
    drn = out_valid && out_ready;
    hold_chk = out_valid && !out_ready && !flush && !rst;
    held_d = out_data;
    held_t = out_tag;
    held_e = out_err;
    if (rst || flush) begin
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(expect_of(sel));
    end
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] keep_d;
    checks   = 0;
    errors   = 0;
    hold_chk = 0;
    srcv[0]  = 16'h1111;
    srcv[1]  = 16'h2222;
    srcv[2]  = 16'h3333;
    rst      = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b1;
    sel      = 2'd0;
    out_ready = 1'b1;
    @(negedge clk);

    // Reset held two cycles with in_valid high
    tick();
    chk("rst_out_data", out_data, 16'h0);
    chk("rst_in_ready", in_ready, 1'b0);
    tick();
    chk("rst_out_valid", out_valid, 1'b0);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1'b1);

    // Basic select, back-to-back
    in_valid = 1'b1;
    sel = 2'd0;
    tick();
    chk("sel0_data", out_data, 16'h1111);
    sel = 2'd1;
    tick();
    chk("sel1_data", out_data, 16'h2222);
    sel = 2'd2;
    tick();
    chk("sel2_data", out_data, 16'h3333);
    chk("sel2_tag", out_tag, 2'd2);

    // Illegal select
    sel = 2'd3;
    tick();
    chk("ill_data", out_data, 16'h0000);
    chk("ill_tag", out_tag, 2'd3);
    chk("ill_err", out_err, 1'b1);
    in_valid = 1'b0;
    tick();

    // Back-pressure
    out_ready = 1'b0;
    in_valid = 1'b1;
    sel = 2'd0;
    tick();
    sel = 2'd1;
    tick();
    sel = 2'd2;
    srcv[1] = 16'hdead;
    tick();
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_hold", out_data, 16'h1111);
    out_ready = 1'b1;
    tick();
    chk("bp_second", out_data, 16'h2222);
    tick();
    chk("bp_third", out_data, 16'h3333);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", out_valid, 1'b0);
    srcv[1] = 16'h2222;

    // Flush in FULL with simultaneous in_valid
    out_ready = 1'b0;
    in_valid = 1'b1;
    sel = 2'd1;
    tick();
    sel = 2'd2;
    tick();
    keep_d = out_data;
    flush = 1'b1;
    in_valid = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_ready", in_ready, 1'b1);
    chk("fl_keep", out_data, keep_d);
    out_ready = 1'b1;
    tick();
    tick();

    // Random phase against the queue model
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      sel       = 2'($urandom_range(0, 3));
      flush     = ($urandom_range(0, 31) == 0);
      rst       = ($urandom_range(0, 499) == 0);
      srcv[0]   = 16'($urandom);
      srcv[1]   = 16'($urandom);
      srcv[2]   = 16'($urandom);
      tick();
    end
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("end_empty", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
